// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment scan driver: glyph patterns, off
// levels, frame record and the code-to-glyph lookup.
package seg_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [3:0] AN_OFF  = 4'hF;

  // Game-specific code aliases (Bulls / Cows markers)
  localparam logic [3:0] GLYPH_B = 4'd11;
  localparam logic [3:0] GLYPH_C = 4'd12;

  // Segment patterns {A..G}, active-low
  localparam logic [6:0] SEG_GLYPH_0 = 7'b0000001;
  localparam logic [6:0] SEG_GLYPH_1 = 7'b1001111;
  localparam logic [6:0] SEG_GLYPH_2 = 7'b0010010;
  localparam logic [6:0] SEG_GLYPH_3 = 7'b0000110;
  localparam logic [6:0] SEG_GLYPH_4 = 7'b1001100;
  localparam logic [6:0] SEG_GLYPH_5 = 7'b0100100;
  localparam logic [6:0] SEG_GLYPH_6 = 7'b0100000;
  localparam logic [6:0] SEG_GLYPH_7 = 7'b0001111;
  localparam logic [6:0] SEG_GLYPH_8 = 7'b0000000;
  localparam logic [6:0] SEG_GLYPH_9 = 7'b0000100;
  localparam logic [6:0] SEG_GLYPH_A = 7'b0001000;
  localparam logic [6:0] SEG_GLYPH_B = 7'b1100000;
  localparam logic [6:0] SEG_GLYPH_C = 7'b0110001;
  localparam logic [6:0] SEG_GLYPH_D = 7'b1000010;
  localparam logic [6:0] SEG_GLYPH_E = 7'b0110000;
  localparam logic [6:0] SEG_GLYPH_F = 7'b0111000;

  typedef struct packed {
    logic [15:0] digits;
    logic [3:0]  blank;
  } frame_t;

  localparam frame_t FRAME_RESET = '{digits: 16'h0000, blank: 4'hF};

  function automatic logic [6:0] code_to_glyph(input logic [3:0] code);
    logic [6:0] glyph;
    glyph = SEG_OFF;
    case (code)
      4'h0:    glyph = SEG_GLYPH_0;
      4'h1:    glyph = SEG_GLYPH_1;
      4'h2:    glyph = SEG_GLYPH_2;
      4'h3:    glyph = SEG_GLYPH_3;
      4'h4:    glyph = SEG_GLYPH_4;
      4'h5:    glyph = SEG_GLYPH_5;
      4'h6:    glyph = SEG_GLYPH_6;
      4'h7:    glyph = SEG_GLYPH_7;
      4'h8:    glyph = SEG_GLYPH_8;
      4'h9:    glyph = SEG_GLYPH_9;
      4'hA:    glyph = SEG_GLYPH_A;
      GLYPH_B: glyph = SEG_GLYPH_B;
      GLYPH_C: glyph = SEG_GLYPH_C;
      4'hD:    glyph = SEG_GLYPH_D;
      4'hE:    glyph = SEG_GLYPH_E;
      default: glyph = SEG_GLYPH_F;
    endcase
    return glyph;
  endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational 4-bit code to active-low 7-segment glyph decoder.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] i_code,
  output logic [6:0] o_glyph
);

  assign o_glyph = code_to_glyph(i_code);

endmodule

// File: rtl/seg_scan_driver.sv
// Double-buffered 4-digit 7-segment scan driver with per-digit blanking,
// whole-display blink and frame-boundary commit of new frames.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned BLINK_FRAMES = 250
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [15:0] load_digits,
  input  logic [3:0]  load_blank,
  input  logic        blink_en,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        frame_tick
);

  localparam int unsigned DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned BLK_W = $clog2(BLINK_FRAMES + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_FRAMES - 1);

  logic [DIV_W-1:0] r_div_cnt;
  logic [1:0]       r_idx;
  logic [BLK_W-1:0] r_blink_cnt;
  logic             r_blink_phase;
  frame_t           r_active;
  frame_t           r_pending;
  logic             r_pend_full;
  logic             r_load_ready;
  logic             r_frame_tick;
  logic [6:0]       r_seg;
  logic [3:0]       r_an;

  logic             w_slot_end;
  logic             w_frame_end;
  logic             w_accept;
  logic             w_pend_full_nxt;
  logic [3:0]       w_code;
  logic [6:0]       w_glyph;
  logic             w_blanked;

  assign w_slot_end  = (r_div_cnt == DIV_LAST);
  assign w_frame_end = w_slot_end && (r_idx == 2'd3);
  assign w_accept    = load_valid && r_load_ready;
  // Accept needs an empty buffer and commit needs a full one, so the two
  // never collide; a frame accepted on a boundary waits for the next one.
  assign w_pend_full_nxt = w_accept || (r_pend_full && !w_frame_end);

  always_comb begin
    w_code = r_active.digits[15:12];
    case (r_idx)
      2'd0:    w_code = r_active.digits[15:12];
      2'd1:    w_code = r_active.digits[11:8];
      2'd2:    w_code = r_active.digits[7:4];
      default: w_code = r_active.digits[3:0];
    endcase
  end

  assign w_blanked = r_active.blank[2'd3 - r_idx] || r_blink_phase;

  seg_hex_decode u_decode (
    .i_code  (w_code),
    .o_glyph (w_glyph)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div_cnt    <= '0;
      r_idx        <= '0;
      r_frame_tick <= 1'b0;
      r_active     <= FRAME_RESET;
      r_pending    <= '0;
      r_pend_full  <= 1'b0;
      r_load_ready <= 1'b0;
    end else begin
      r_div_cnt    <= w_slot_end ? '0 : r_div_cnt + DIV_W'(1);
      if (w_slot_end) r_idx <= r_idx + 2'd1;
      r_frame_tick <= w_frame_end;
      if (w_frame_end && r_pend_full) r_active <= r_pending;
      if (w_accept) r_pending <= '{digits: load_digits, blank: load_blank};
      r_pend_full  <= w_pend_full_nxt;
      r_load_ready <= !w_pend_full_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (!blink_en) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (w_frame_end) begin
      if (r_blink_cnt == BLK_LAST) begin
        r_blink_cnt   <= '0;
        r_blink_phase <= !r_blink_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + BLK_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_seg <= SEG_OFF;
      r_an  <= AN_OFF;
    end else if (w_blanked) begin
      r_seg <= SEG_OFF;
      r_an  <= AN_OFF;
    end else begin
      r_seg <= w_glyph;
      r_an  <= ~(4'b1000 >> r_idx);
    end
  end

  assign seg        = r_seg;
  assign an         = r_an;
  assign frame_tick = r_frame_tick;
  assign load_ready = r_load_ready;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver: frame-level reference model,
// table-driven display vectors, hand sequences and randomized traffic.
module tb_seg_scan_driver;

  localparam int unsigned RD = 4;
  localparam int unsigned BF = 2;
  localparam int FRAME = 4 * RD;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_digits;
  logic [3:0]  load_blank;
  logic        blink_en;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_tick;

  always #5 clk = ~clk;

  seg_scan_driver #(.REFRESH_DIV(RD), .BLINK_FRAMES(BF)) dut (
    .clk         (clk),
    .reset       (reset),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_digits (load_digits),
    .load_blank  (load_blank),
    .blink_en    (blink_en),
    .seg         (seg),
    .an          (an),
    .frame_tick  (frame_tick)
  );

  int checks = 0;
  int errors = 0;

  logic [6:0] glyph_tab [16];

  // Reference model: time is a cycle count since reset release, the scan
  // position and blink phase are derived from it arithmetically.
  int          m_n;
  int          m_pre_n;
  logic [15:0] m_act_d;
  logic [3:0]  m_act_b;
  logic [15:0] m_pen_d;
  logic [3:0]  m_pen_b;
  bit          m_full;
  bit          m_ready;
  bit          m_tick;
  int          m_bframes;
  int          m_commit_n;
  int          m_accept_n;

  typedef struct {
    logic [15:0]      d;
    logic [3:0]       b;
    logic [3:0][3:0]  exp_an;
    logic [3:0][6:0]  exp_seg;
  } vec_t;
  vec_t vt [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_n = 0; m_pre_n = 0;
    m_act_d = 16'h0000; m_act_b = 4'hF;
    m_pen_d = 16'h0000; m_pen_b = 4'h0;
    m_full = 0; m_ready = 0; m_tick = 0; m_bframes = 0;
    m_commit_n = -100; m_accept_n = -100;
  endtask

  task automatic step();
    int idx;
    bit ph, fe, acc;
    logic [6:0] e_seg;
    logic [3:0] e_an;
    idx = (m_n / RD) % 4;
    ph  = ((m_bframes / BF) % 2) == 1;
    if (m_act_b[3-idx] || ph) begin
      e_seg = 7'h7F; e_an = 4'hF;
    end else begin
      e_an  = 4'hF & ~(4'b0001 << (3 - idx));
      e_seg = glyph_tab[m_act_d[(3-idx)*4 +: 4]];
    end
    fe  = (m_n % FRAME) == FRAME - 1;
    acc = load_valid && m_ready;
    m_pre_n = m_n;
    @(posedge clk);
    if (fe && m_full) begin
      m_act_d = m_pen_d; m_act_b = m_pen_b; m_full = 0; m_commit_n = m_n;
    end
    if (acc) begin
      m_pen_d = load_digits; m_pen_b = load_blank; m_full = 1; m_accept_n = m_n;
    end
    if (!blink_en) m_bframes = 0;
    else if (fe) m_bframes++;
    m_ready = !m_full;
    m_tick  = fe;
    m_n++;
    #1;
    check("seg", 32'(seg), 32'(e_seg));
    check("an", 32'(an), 32'(e_an));
    check("frame_tick", 32'(frame_tick), 32'(m_tick));
    check("load_ready", 32'(load_ready), 32'(m_ready));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    load_valid = 1'b0;
    blink_en = 1'b0;
    #1;
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_an", 32'(an), 32'hF);
    check("rst_tick", 32'(frame_tick), 32'h0);
    check("rst_ready", 32'(load_ready), 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic load(input logic [15:0] d, input logic [3:0] b, input bit hold);
    bit acc;
    bit done;
    done = 0;
    load_valid = 1'b1; load_digits = d; load_blank = b;
    for (int i = 0; i < 4 * FRAME && !done; i++) begin
      acc = m_ready;
      step();
      if (acc) done = 1;
    end
    if (!done) check("load_timeout", 32'h0, 32'h1);
    if (!hold) load_valid = 1'b0;
  endtask

  task automatic wait_commit();
    bit done;
    done = 0;
    for (int i = 0; i < 4 * FRAME && !done; i++) begin
      if (!m_full && (m_n % FRAME) == 0) done = 1;
      else step();
    end
    if (!done) check("commit_timeout", 32'h0, 32'h1);
  endtask

  initial begin
    int ticks, lit, slot;
    glyph_tab[0] = 7'b0000001; glyph_tab[1] = 7'b1001111;
    glyph_tab[2] = 7'b0010010; glyph_tab[3] = 7'b0000110;
    glyph_tab[4] = 7'b1001100; glyph_tab[5] = 7'b0100100;
    glyph_tab[6] = 7'b0100000; glyph_tab[7] = 7'b0001111;
    glyph_tab[8] = 7'b0000000; glyph_tab[9] = 7'b0000100;
    glyph_tab[10] = 7'b0001000; glyph_tab[11] = 7'b1100000;
    glyph_tab[12] = 7'b0110001; glyph_tab[13] = 7'b1000010;
    glyph_tab[14] = 7'b0110000; glyph_tab[15] = 7'b0111000;

    // exp_* fields listed slot0 (leftmost) first, so element [3-slot]
    vt[0] = '{16'hB2C1, 4'b0000, {4'b0111, 4'b1011, 4'b1101, 4'b1110},
              {7'b1100000, 7'b0010010, 7'b0110001, 7'b1001111}};
    vt[1] = '{16'h0001, 4'b1110, {4'hF, 4'hF, 4'hF, 4'b1110},
              {7'h7F, 7'h7F, 7'h7F, 7'b1001111}};
    vt[2] = '{16'h8E0F, 4'b0101, {4'b0111, 4'hF, 4'b1101, 4'hF},
              {7'b0000000, 7'h7F, 7'b0000001, 7'h7F}};
    vt[3] = '{16'hA9D6, 4'b0000, {4'b0111, 4'b1011, 4'b1101, 4'b1110},
              {7'b0001000, 7'b0000100, 7'b1000010, 7'b0100000}};

    reset = 1'b1; load_valid = 1'b0; blink_en = 1'b0;
    load_digits = '0; load_blank = '0;
    model_reset();

    // Idle after reset: nothing lit, one tick per frame
    do_reset();
    ticks = 0; lit = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      step();
      if (frame_tick) ticks++;
      if (an != 4'hF) lit++;
    end
    check("idle_ticks", 32'(ticks), 32'd3);
    check("idle_dark", 32'(lit), 32'd0);

    // Table-driven frames, checked slot by slot in the first full frame
    for (int v = 0; v < 4; v++) begin
      do_reset();
      repeat (3) step();
      load(vt[v].d, vt[v].b, 1'b0);
      check("tab_ready_low", 32'(load_ready), 32'h0);
      wait_commit();
      for (int c = 0; c < FRAME; c++) begin
        step();
        slot = (m_pre_n % FRAME) / RD;
        check("tab_an", 32'(an), 32'(vt[v].exp_an[3-slot]));
        check("tab_seg", 32'(seg), 32'(vt[v].exp_seg[3-slot]));
      end
    end

    // Back-to-back loads with load_valid held
    do_reset();
    step();
    load(16'h0001, 4'h0, 1'b1);
    load(16'h0002, 4'h0, 1'b0);
    check("b2b_gap", 32'(m_accept_n), 32'(m_commit_n + 1));
    repeat (3 * FRAME) step();

    // Blink for several frames, then release
    do_reset();
    load(16'h0001, 4'h0, 1'b0);
    wait_commit();
    blink_en = 1'b1;
    repeat (5 * FRAME) step();
    blink_en = 1'b0;
    repeat (FRAME) step();

    // Pending frame discarded by reset before its boundary
    do_reset();
    load(16'h0001, 4'hE, 1'b0);
    wait_commit();
    repeat (5) step();
    load(16'h1234, 4'h0, 1'b0);
    step();
    do_reset();
    lit = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      step();
      if (an != 4'hF) lit++;
    end
    check("discard_dark", 32'(lit), 32'd0);

    // Randomized producer traffic against the model
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if (!load_valid || m_accept_n == m_n - 1) begin
        load_valid  = ($urandom_range(0, 3) == 0);
        load_digits = 16'($urandom);
        load_blank  = 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 99) == 0) blink_en = ~blink_en;
      if ($urandom_range(0, 499) == 0) do_reset();
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
Downstream display stage for the Bulls-and-Cows game core. It accepts 4-digit frames of hex/glyph codes, double-buffers them, and time-multiplexes them onto one shared 7-segment bus with active-low anodes. New frames are committed only at frame boundaries, so the display never shows half-old, half-new digits. It also provides per-digit blanking and whole-display blink for the winner indication.

Parameters:
REFRESH_DIV, 50000, clk cycles per digit slot (100 MHz gives 2 kHz digit rate and 500 Hz frame rate); must be >= 2
BLINK_FRAMES, 250, frames per blink half-period (0.5 s at 500 Hz); must be >= 1

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high
load_valid  in  1  producer has a frame to load
load_ready  out  1  pending buffer empty; frame accepted when load_valid && load_ready
load_digits  in  16  4 codes; [15:12] = digit0 (leftmost) ... [3:0] = digit3 (rightmost)
load_blank  in  4  load_blank[3] blanks digit0 ... load_blank[0] blanks digit3
blink_en  in  1  level; when high, whole display blinks
seg  out  7  segments {A..G}, A = MSB, active-low
an  out  4  anodes, active-low; 0111 = digit0, 1110 = digit3
frame_tick  out  1  one-cycle pulse at each frame boundary

Behaviour:
- Clock is clk. Reset is asynchronous, active-high.
- Reset values:
  - seg = 7'b1111111, an = 4'b1111, frame_tick = 0, load_ready = 0.
  - Active and pending digits = 0. Active blank = 4'b1111. Pending-full = 0.
  - div_cnt = 0, idx = 0, blink_cnt = 0, blink_phase = 0.
  - Nothing is shown until the first commit. A reset asserted mid-operation discards the pending frame immediately.
- load_ready = !pending_full (registered; 1 from the first cycle after reset deasserts).
- Scan timing:
  - div_cnt counts 0..REFRESH_DIV-1 and wraps.
  - slot_end = (div_cnt == REFRESH_DIV-1). On slot_end, idx increments mod 4.
  - frame_end = slot_end && idx == 3. frame_tick is frame_end registered, so it pulses in the cycle where idx becomes 0.
- Handshake:
  - Accept when load_valid && load_ready: capture load_digits and load_blank into pending, set pending_full.
  - On frame_end with pending_full: pending is copied to active and pending_full is cleared, so load_ready rises the next cycle.
  - Accept and frame_end in the same cycle with pending empty: the new frame is held and commits at the next boundary, not the current one.
  - load_valid while not ready: ignored. The producer must hold it.
- Blink:
  - When blink_en = 1, blink_cnt counts frame_end events. On reaching BLINK_FRAMES-1 it clears and blink_phase toggles.
  - When blink_en = 0, blink_cnt and blink_phase are held at 0.
  - Every digit is treated as blanked whenever blink_phase = 1.
- Output register, updated every cycle from the current idx and active buffer:
  - If the digit is blanked (blank bit or blink_phase): an = 4'b1111, seg = 7'b1111111.
  - Otherwise: an = ~(4'b1000 >> idx), seg = decode(code).
  - Output latency is 1 cycle after an idx change.
- Decode table:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000

Decomposition:
- Package seg_pkg holds:
  - the 16 glyph constants, with GLYPH_B = 11 and GLYPH_C = 12 code aliases
  - SEG_OFF = 7'h7F and AN_OFF = 4'hF
  - the code-to-glyph function
- Sub-module seg_hex_decode: purely combinational, 4-bit code in, 7-bit glyph out.
- Top holds the divider, handshake, double buffer, blink logic and output registers.

Test Plan:
All tests use REFRESH_DIV=4 and BLINK_FRAMES=2, so one frame = 16 cycles.
1. Hold reset, then release without loading -> seg=7F and an=F during reset; load_ready=1 from the first cycle after release; an stays F through 3 frames; frame_tick pulses every 16 cycles.
2. Load digits=0xB2C1, blank=0 -> load_ready=0 until the next frame_end. In the frame after that, each state lasts 4 cycles: an=0111/seg=1100000, then 1011/0010010, then 1101/0110001, then 1110/1001111.
3. Hold load_valid for 0x0001 then 0x0002 back-to-back -> the second frame is not accepted until the cycle after the first commits. The display shows 0001 for one frame, then 0002.
4. Load digits=0x0001, blank=4'b1110 -> only the rightmost slot lights (an=1110, seg=1001111); an=1111 in the other 3 slots.
5. Load 0x0001, then set blink_en=1 -> the display alternates 2 frames blanked and 2 frames visible. Dropping blink_en makes it visible at the next output update.
6. Accept a frame mid-frame, then assert reset before frame_end -> outputs go off immediately, the pending frame never appears, and load_ready=1 after release.
